res_drain: RTL and testbench
============================

# res_drain

Drains accumulated results out of a cascaded chain of MAC units and requantizes them for the output stream. After accumulation completes, it pulses the chain's `Res_en` to shift each unit's result out of the last unit's `Res_cascade` port. Each captured value is rounded, shifted and saturated to `OUT_W` bits, then buffered in a small FIFO behind a valid/ready output. It sits directly downstream of the MAC chain, between the array and the output writer.

## Interface
- `RES_W`, 32, width of `Res_cascade` values (matches MAC unit `RES_W`)
- `OUT_W`, 8, width of requantized output
- `CHAIN_LEN`, 4, number of MAC units in the chain (results per drain)
- `FIFO_D`, 4, output FIFO depth (power of two, ≥2)
- `SHIFT_W`, `$clog2(RES_W)`, width of `shift_amt`

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-low reset
- `start` in 1: one-cycle pulse; chain accumulation complete, begin drain
- `shift_amt` in `SHIFT_W`: right-shift amount; sampled on accepted `start`
- `Res_cascade_in` in `RES_W`: signed result from last MAC unit `Res_cascade`
- `Res_en_out` out 1: drives chain `Res_en` (upstream forces `Res_in` = 0 during drain)
- `busy` out 1: drain in progress
- `done` out 1: one-cycle pulse when all `CHAIN_LEN` results have left the FIFO
- `out_data` out `OUT_W`: signed requantized result
- `out_valid` out 1: `out_data` valid
- `out_ready` in 1: consumer accepts when `out_valid && out_ready`

## Operation
- **States:** IDLE, DRAIN, FLUSH.
- **IDLE:**
  - `start`=1 latches `shift_amt` (clamped to `RES_W-1`), clears capture counter `cnt`, and moves to DRAIN.
  - `start` in any other state is ignored.
- **DRAIN:**
  - `Res_en_out` = (FIFO count < `FIFO_D`) registered-free, i.e. combinational from the current count. No write-bypass credit is taken for a same-cycle pop.
  - On each edge where `Res_en_out`=1:
    - `Res_cascade_in` is captured (element `cnt`), requantized and written to the FIFO.
    - `cnt` increments.
    - The chain shifts, so element `cnt+1` is present the next cycle.
  - When the `CHAIN_LEN`-th capture occurs, move to FLUSH.
- **FLUSH:** `Res_en_out`=0. When the FIFO becomes empty (last pop accepted), pulse `done` for one cycle and return to IDLE.
- `busy` = state ≠ IDLE.
- **Requantize**, with s = latched shift and x = signed `Res_cascade_in` extended to `RES_W+1` bits:
  - If s>0: y = (x + 2^(s-1)) >>> s. Rounding is half-up toward +inf; the arithmetic shift keeps the sign.
  - If s=0: y = x.
  - Saturate y to [−2^(OUT_W−1), 2^(OUT_W−1)−1].
- **FIFO:**
  - Write and read may occur in the same cycle.
  - Write only occurs when not full, which is guaranteed by the `Res_en_out` gating.
  - Read occurs when `out_valid && out_ready`.
  - Pointers wrap modulo `FIFO_D`; the count is `$clog2(FIFO_D)+1` bits.
  - `out_valid` = FIFO not empty; `out_data` = head entry (registered storage).

## Timing
- **Reset values** (asynchronous on `reset`=0): `Res_en_out`=0, `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, state=IDLE, FIFO empty, `cnt`=0.
- **Reset mid-drain:** all state is discarded, no `done` is issued, and the chain is not restored.
- **Start latency:** `start` at edge t → `busy`=1 and `Res_en_out`=1 in cycle t+1 (FIFO not full).
- **Capture-to-output latency:** capture at edge t → `out_valid`=1 during cycle t+1 when the FIFO was empty.
- **Throughput:** with `out_ready` held high, one result per cycle. `CHAIN_LEN` captures take `CHAIN_LEN` consecutive cycles.
- **Backpressure:** with `out_ready`=0, exactly `FIFO_D` captures occur, then `Res_en_out`=0 until a pop frees a slot. `Res_en_out` reasserts in the cycle after the pop.
- **Done latency:** `done` is asserted in the cycle after the edge at which the last entry pops. `busy` falls in that same cycle.
- **CHAIN_LEN < FIFO_D:** DRAIN never stalls.

## Structure
- Package `res_drain_pkg`:
  - state enum `drain_state_t {IDLE, DRAIN, FLUSH}`
  - function `requant(x, s)` implementing round/shift/saturate, parameterized via localparams in the module
- Sub-module `sync_fifo`:
  - parameters: `WIDTH`, `DEPTH`
  - ports: `clk`, `reset` (async active-low), `wr_en`, `wr_data`, `rd_en`, `rd_data`, `full`, `empty`, `count`
- `res_drain` holds the FSM, counter, shift latch and requant path.

## Test plan
- **Basic drain:** `CHAIN_LEN`=4, s=0, chain values 5, −3, 127, −128, `out_ready`=1 → `Res_en_out` high for 4 cycles; outputs 5, −3, 127, −128 in order; `done` one cycle after the last pop.
- **Rounding and saturation:** s=4, inputs 24, 23, −24, 5000, −5000 → outputs 2, 1, −1, 127, −128. The −24 case checks half-up: (−24+8)>>>4 = −1.
- **Backpressure:** `FIFO_D`=4, `CHAIN_LEN`=6, `out_ready`=0 → exactly 4 `Res_en_out` pulses, then stall. Raising `out_ready` resumes one capture per pop; all 6 outputs arrive in order; `done` once.
- **Ignored start:** `start` pulsed during DRAIN and FLUSH → no restart, `cnt` unaffected, a single `done`. A new `start` after `done` drains again correctly.
- **Reset mid-drain:** assert `reset` after 2 captures → all outputs read 0 immediately. After release, `start` performs a full clean drain.
- **shift_amt clamp:** `shift_amt`=31 with `RES_W`=32, input 0x4000_0000 → output 1 (rounded); input −1 → output 0.

Source files
------------

// File: rtl/res_drain_pkg.sv
// Shared types and the requantization helper for the result drain path.
package res_drain_pkg;

   // FSM state encoding, fixed so it matches the legacy two-bit encoding
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRAIN = 2'd1,
      FLUSH = 2'd2
   } drain_state_t;

   // Working width for requant; wide enough for any RES_W+1 sum used here
   localparam int unsigned REQ_W = 64;

   // Round half-up, arithmetic right shift by s, saturate to out_w signed bits.
   // Caller sign-extends the input and truncates the result to its widths.
   function automatic logic signed [REQ_W-1:0] requant(
      input logic signed [REQ_W-1:0] x,
      input int unsigned             s,
      input int unsigned             out_w
   );
      logic signed [REQ_W-1:0] y;
      logic signed [REQ_W-1:0] hi;
      logic signed [REQ_W-1:0] lo;
      if (s > 0) begin
         y = (x + (64'sd1 <<< (s - 1))) >>> s;
      end else begin
         y = x;
      end
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (y > hi) begin
         y = hi;
      end else if (y < lo) begin
         y = lo;
      end
      return y;
   endfunction

endpackage

// File: rtl/res_drain_sync_fifo.sv
// Small synchronous FIFO with registered storage; head entry drives rd_data.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_ok, rd_ok;

   assign full    = (count_q == (AW+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   // Next-state for storage, pointers (natural power-of-two wrap) and count
   always_comb begin
      wr_ok    = wr_en && !full;
      rd_ok    = rd_en && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_ok) begin
         mem_d[wr_ptr_q] = wr_data;
         wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (rd_ok) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + {{AW{1'b0}}, wr_ok} - {{AW{1'b0}}, rd_ok};
   end

   // FIFO state registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/res_drain.sv
// Drains a MAC chain via Res_en, requantizes each result into a small output FIFO.
module res_drain
   import res_drain_pkg::*;
#(
   parameter int RES_W     = 32,
   parameter int OUT_W     = 8,
   parameter int CHAIN_LEN = 4,
   parameter int FIFO_D    = 4,
   parameter int SHIFT_W   = $clog2(RES_W)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [SHIFT_W-1:0]  shift_amt,
   input  logic [RES_W-1:0]    Res_cascade_in,
   output logic                Res_en_out,
   output logic                busy,
   output logic                done,
   output logic [OUT_W-1:0]    out_data,
   output logic                out_valid,
   input  logic                out_ready
);

   localparam int CNT_W  = $clog2(CHAIN_LEN + 1);
   localparam int FCNT_W = $clog2(FIFO_D) + 1;

   drain_state_t         state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [SHIFT_W-1:0]   shift_q, shift_d;
   logic                 done_q, done_d;
   logic                 res_en;
   logic                 rd_en;
   logic [OUT_W-1:0]     wr_data;
   logic                 fifo_full, fifo_empty;
   logic [FCNT_W-1:0]    fifo_count;
   logic signed [REQ_W-1:0] x_ext;

   assign rd_en      = !fifo_empty && out_ready;
   assign out_valid  = !fifo_empty;
   assign busy       = (state_q != IDLE);
   assign done       = done_q;
   assign Res_en_out = res_en;

   // Requantize the value currently presented by the chain
   always_comb begin
      x_ext   = REQ_W'(signed'(Res_cascade_in));
      wr_data = OUT_W'(requant(x_ext, 32'(shift_q), 32'(OUT_W)));
   end

   // Drain FSM: start latch, Res_en gating on free FIFO space, capture count, done
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      res_en  = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (32'(shift_amt) > 32'(RES_W - 1)) begin
                  shift_d = SHIFT_W'(RES_W - 1);
               end else begin
                  shift_d = shift_amt;
               end
               cnt_d   = '0;
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            res_en = !fifo_full;
            if (res_en) begin
               cnt_d = cnt_q + CNT_W'(1);
               if (cnt_q == CNT_W'(CHAIN_LEN - 1)) begin
                  state_d = FLUSH;
               end
            end
         end
         FLUSH: begin
            // last entry leaving at this edge; done is registered so it lands next cycle
            if (fifo_count == FCNT_W'(1) && rd_en) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Control registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         shift_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         done_q  <= done_d;
      end
   end

   sync_fifo #(
      .WIDTH (OUT_W),
      .DEPTH (FIFO_D)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (res_en),
      .wr_data (wr_data),
      .rd_en   (rd_en),
      .rd_data (out_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

endmodule

// File: tb/tb_res_drain.sv
// Scoreboard bench for res_drain with a behavioural MAC chain model.
module tb_res_drain;

   localparam int CL = 6;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [4:0]  shift_amt;
   logic [31:0] res_cascade;
   logic        res_en;
   logic        busy;
   logic        done;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;

   int checks = 0;
   int errors = 0;

   int chain [CL];
   int cap_total = 0;
   int base = 0;
   int idx;
   int done_cnt = 0;
   logic [7:0] exp_q [$];
   logic exp_done = 1'b0;

   always #5 clk = ~clk;

   res_drain #(
      .RES_W     (32),
      .OUT_W     (8),
      .CHAIN_LEN (CL),
      .FIFO_D    (4)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .shift_amt      (shift_amt),
      .Res_cascade_in (res_cascade),
      .Res_en_out     (res_en),
      .busy           (busy),
      .done           (done),
      .out_data       (out_data),
      .out_valid      (out_valid),
      .out_ready      (out_ready)
   );

   // Chain model: element idx sits at the last unit; Res_en shifts the next one in
   assign idx = cap_total - base;
   assign res_cascade = (idx >= 0 && idx < CL) ? 32'(chain[idx]) : 32'hDEAD_BEEF;

   always @(posedge clk) begin
      if (res_en) cap_total <= cap_total + 1;
   end

   // Monitor: pops the scoreboard on each accepted output, checks the done pulse
   always @(negedge clk) begin
      logic [7:0] e;
      if (!reset) begin
         exp_done = 1'b0;
      end else begin
         if (done) done_cnt++;
         if (done || exp_done) begin
            checks++;
            if (done !== exp_done || (exp_done && busy !== 1'b0)) begin
               errors++;
               $display("FAIL done_pulse got done=%0b busy=%0b expected done=%0b busy=0",
                        done, busy, exp_done);
            end
         end
         exp_done = 1'b0;
         if (out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output got %0d expected none", $signed(out_data));
            end else begin
               e = exp_q.pop_front();
               if (out_data !== e) begin
                  errors++;
                  $display("FAIL out_data got %0d expected %0d", $signed(out_data), $signed(e));
               end
               if (exp_q.size() == 0) exp_done = 1'b1;
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic align();
      @(posedge clk);
      #1;
   endtask

   task automatic run_drain(input logic [4:0] s, input int v [CL], input int e [CL]);
      base = cap_total;
      for (int i = 0; i < CL; i++) begin
         chain[i] = v[i];
         exp_q.push_back(8'(e[i]));
      end
      start     = 1'b1;
      shift_amt = s;
      align();
      start     = 1'b0;
   endtask

   task automatic wait_caps(input string name, input int n);
      int k = 0;
      while ((cap_total - base) < n && k < 200) begin
         align();
         k++;
      end
      check({name, "_caps"}, 32'(cap_total - base), 32'(n));
   endtask

   task automatic wait_idle(input string name);
      int k = 0;
      @(negedge clk);
      while ((busy || exp_q.size() != 0) && k < 300) begin
         @(negedge clk);
         k++;
      end
      checks++;
      if (busy || exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout got busy=%0b pending=%0d expected idle", name, busy, exp_q.size());
      end
      repeat (2) @(negedge clk);
      align();
   endtask

   initial begin
      int d0;
      reset     = 1'b0;
      start     = 1'b0;
      shift_amt = '0;
      out_ready = 1'b0;
      for (int i = 0; i < CL; i++) chain[i] = 0;

      // Reset state
      #12;
      check("rst_res_en", 32'(res_en), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data", 32'(out_data), 0);
      @(negedge clk);
      reset = 1'b1;
      align();

      // Basic drain, s=0, ready high: Res_en high for CL consecutive cycles
      out_ready = 1'b1;
      d0 = done_cnt;
      run_drain(5'd0, '{5, -3, 127, -128, 0, 1}, '{5, -3, 127, -128, 0, 1});
      for (int i = 0; i < CL; i++) begin
         @(negedge clk);
         check("basic_en", 32'(res_en), 1);
         if (i == 0) check("basic_busy", 32'(busy), 1);
         if (i == 1) check("basic_valid", 32'(out_valid), 1);
      end
      @(negedge clk);
      check("basic_en_off", 32'(res_en), 0);
      wait_idle("basic");
      check("basic_done_cnt", 32'(done_cnt - d0), 1);
      check("basic_caps", 32'(cap_total - base), CL);

      // Rounding and saturation, s=4
      d0 = done_cnt;
      run_drain(5'd4, '{24, 23, -24, 5000, -5000, 8}, '{2, 1, -1, 127, -128, 1});
      wait_idle("round");
      check("round_done_cnt", 32'(done_cnt - d0), 1);

      // Backpressure: 4 captures then stall, resume one per pop
      out_ready = 1'b0;
      d0 = done_cnt;
      run_drain(5'd0, '{10, 20, 30, 40, 50, 60}, '{10, 20, 30, 40, 50, 60});
      repeat (12) align();
      check("bp_stall_caps", 32'(cap_total - base), 4);
      @(negedge clk);
      check("bp_stall_en", 32'(res_en), 0);
      check("bp_stall_busy", 32'(busy), 1);
      align();
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_pre_pop_en", 32'(res_en), 0);
      @(negedge clk);
      check("bp_resume_en", 32'(res_en), 1);
      wait_idle("bp");
      check("bp_done_cnt", 32'(done_cnt - d0), 1);
      check("bp_caps", 32'(cap_total - base), CL);

      // Ignored start in DRAIN and FLUSH
      out_ready = 1'b0;
      d0 = done_cnt;
      run_drain(5'd0, '{1, 2, 3, 4, 5, 6}, '{1, 2, 3, 4, 5, 6});
      repeat (8) align();
      start = 1'b1;
      shift_amt = 5'd4;
      align();
      start = 1'b0;
      out_ready = 1'b1;
      wait_caps("ign", CL);
      out_ready = 1'b0;
      start = 1'b1;
      align();
      start = 1'b0;
      @(negedge clk);
      check("ign_flush_busy", 32'(busy), 1);
      check("ign_flush_en", 32'(res_en), 0);
      align();
      out_ready = 1'b1;
      wait_idle("ign");
      repeat (3) align();
      check("ign_done_cnt", 32'(done_cnt - d0), 1);
      check("ign_caps", 32'(cap_total - base), CL);
      check("ign_no_restart", 32'(busy), 0);

      // New drain after done, s=1
      d0 = done_cnt;
      run_drain(5'd1, '{-1, 3, -3, 255, -300, 1}, '{0, 2, -1, 127, -128, 1});
      wait_idle("redrain");
      check("redrain_done_cnt", 32'(done_cnt - d0), 1);

      // Reset mid-drain after 2 captures
      out_ready = 1'b0;
      d0 = done_cnt;
      run_drain(5'd0, '{33, 44, 55, 66, 77, 88}, '{33, 44, 55, 66, 77, 88});
      wait_caps("mid", 2);
      #2;
      reset = 1'b0;
      exp_q.delete();
      #1;
      check("mid_res_en", 32'(res_en), 0);
      check("mid_busy", 32'(busy), 0);
      check("mid_done", 32'(done), 0);
      check("mid_valid", 32'(out_valid), 0);
      check("mid_data", 32'(out_data), 0);
      repeat (2) align();
      reset = 1'b1;
      repeat (2) align();
      check("mid_no_done", 32'(done_cnt - d0), 0);
      out_ready = 1'b1;
      d0 = done_cnt;
      run_drain(5'd0, '{7, -7, 9, -9, 11, -11}, '{7, -7, 9, -9, 11, -11});
      wait_idle("post_rst");
      check("post_rst_done_cnt", 32'(done_cnt - d0), 1);
      check("post_rst_caps", 32'(cap_total - base), CL);

      // Maximum shift
      d0 = done_cnt;
      run_drain(5'd31, '{32'h4000_0000, -1, 32'h7FFF_FFFF, 32'h8000_0000, 0, 2},
                       '{1, 0, 1, -1, 0, 0});
      wait_idle("shift31");
      check("shift31_done_cnt", 32'(done_cnt - d0), 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
